// File: rtl/db_multi_fsm.sv
// ---------------------------------------------------------------------------
// db_multi_fsm
//   Multi-channel switch debouncer. CHANNELS independent raw inputs share one
//   free-running tick prescaler. Each input is synchronised, then has to hold
//   a new level for STABLE_TICKS consecutive ticks before its debounced level
//   changes. One-cycle rise/fall pulses and a registered "changed" flag are
//   produced for downstream UI/control logic.
//
// Parameters
//   CHANNELS      number of independent switch inputs (>=1)
//   TICK_BITS     prescaler width, tick period = 2**TICK_BITS clk cycles (>=1)
//   STABLE_TICKS  consecutive ticks a new level must persist (>=1)
//   SYNC_STAGES   flops in each input synchroniser (>=2)
//   INIT_LEVEL    level of sync flops, FSM state and db after reset (0 or 1)
//
// Ports
//   clk      in   1         system clock, rising edge
//   reset    in   1         asynchronous, active-low reset
//   sw       in   CHANNELS  raw asynchronous switch inputs
//   db       out  CHANNELS  debounced levels, registered
//   rise     out  CHANNELS  1-cycle pulse when db[i] goes 0->1
//   fall     out  CHANNELS  1-cycle pulse when db[i] goes 1->0
//   changed  out  1         registered OR of all rise/fall pulses
// ---------------------------------------------------------------------------
module db_multi_fsm #(
  parameter int CHANNELS     = 4,
  parameter int TICK_BITS    = 19,
  parameter int STABLE_TICKS = 3,
  parameter int SYNC_STAGES  = 2,
  parameter int INIT_LEVEL   = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] sw,
  output logic [CHANNELS-1:0] db,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                changed
);

  localparam int             CNT_W    = $clog2(STABLE_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);
  localparam logic           INIT_BIT = (INIT_LEVEL != 0);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_t;

  localparam state_t RESET_STATE = INIT_BIT ? STABLE_HI : STABLE_LO;

  // -------------------------------------------------------------------------
  // Shared prescaler: one tick every 2**TICK_BITS cycles
  // -------------------------------------------------------------------------
  logic [TICK_BITS-1:0] q;
  logic                 tick;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of the others; blocking here would create ordering races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q <= '0;
    else        q <= q + 1'b1;
  end

  assign tick = &q;

  // -------------------------------------------------------------------------
  // Input synchronisers; the FSMs only ever look at s
  // -------------------------------------------------------------------------
  logic [CHANNELS-1:0][SYNC_STAGES-1:0] sync_q;
  logic [CHANNELS-1:0]                  s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= {(CHANNELS*SYNC_STAGES){INIT_BIT}};
    end else begin
      for (int i = 0; i < CHANNELS; i++)
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], sw[i]};
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) s[i] = sync_q[i][SYNC_STAGES-1];
  end

  // -------------------------------------------------------------------------
  // Per-channel FSM: state register
  // -------------------------------------------------------------------------
  state_t                         state_q [CHANNELS];
  state_t                         state_d [CHANNELS];
  logic [CHANNELS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [CHANNELS-1:0]            db_d, rise_d, fall_d;

  // NOTE: every control flop, including the FSM state and counters, is in
  // the async reset so a reset discards any partial debounce count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < CHANNELS; i++) state_q[i] <= RESET_STATE;
      cnt_q   <= '0;
      db      <= {CHANNELS{INIT_BIT}};
      rise    <= '0;
      fall    <= '0;
      changed <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) state_q[i] <= state_d[i];
      cnt_q   <= cnt_d;
      db      <= db_d;
      rise    <= rise_d;
      fall    <= fall_d;
      changed <= |(rise | fall);
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic. A level that reverts on a tick cycle wins over the
  // tick, so the glitch is rejected without counting.
  // -------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      // NOTE: defaults first, so no path through the case leaves a variable
      // unassigned and no latch is inferred.
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        STABLE_LO: if (s[i]) begin
          state_d[i] = WAIT_HI;
          cnt_d[i]   = '0;
        end
        WAIT_HI: begin
          if (!s[i])                      state_d[i] = STABLE_LO;
          else if (tick) begin
            if (cnt_q[i] == CNT_LAST)     state_d[i] = STABLE_HI;
            else                          cnt_d[i]   = cnt_q[i] + 1'b1;
          end
        end
        STABLE_HI: if (!s[i]) begin
          state_d[i] = WAIT_LO;
          cnt_d[i]   = '0;
        end
        WAIT_LO: begin
          if (s[i])                       state_d[i] = STABLE_HI;
          else if (tick) begin
            if (cnt_q[i] == CNT_LAST)     state_d[i] = STABLE_LO;
            else                          cnt_d[i]   = cnt_q[i] + 1'b1;
          end
        end
        default: begin
          state_d[i] = STABLE_LO;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Output logic: db only moves on the completing tick of a WAIT state, and
  // the matching edge pulse is registered on that same edge.
  // -------------------------------------------------------------------------
  always_comb begin
    db_d   = db;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      case (state_q[i])
        WAIT_HI: if (s[i] && tick && (cnt_q[i] == CNT_LAST)) begin
          db_d[i]   = 1'b1;
          rise_d[i] = 1'b1;
        end
        WAIT_LO: if (!s[i] && tick && (cnt_q[i] == CNT_LAST)) begin
          db_d[i]   = 1'b0;
          fall_d[i] = 1'b1;
        end
        STABLE_LO, STABLE_HI: ;
        default: db_d[i] = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_db_multi_fsm.sv
// ---------------------------------------------------------------------------
// tb_db_multi_fsm
//   Directed bench for db_multi_fsm with CHANNELS=4, TICK_BITS=2,
//   STABLE_TICKS=3, SYNC_STAGES=2. A second instance built with INIT_LEVEL=1
//   sits alongside the main INIT_LEVEL=0 instance. Inputs change on the
//   falling edge; outputs are sampled 1 time unit after the rising edge.
//   Edge 1 is the first rising edge after an input change.
// ---------------------------------------------------------------------------
module tb_db_multi_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sw, sw_hi;
  logic [3:0] db, rise, fall;
  logic       changed;
  logic [3:0] db_hi, rise_hi, fall_hi;
  logic       changed_hi;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  db_multi_fsm #(
    .CHANNELS(4), .TICK_BITS(2), .STABLE_TICKS(3), .SYNC_STAGES(2), .INIT_LEVEL(0)
  ) dut (
    .clk(clk), .reset(reset), .sw(sw),
    .db(db), .rise(rise), .fall(fall), .changed(changed)
  );

  db_multi_fsm #(
    .CHANNELS(4), .TICK_BITS(2), .STABLE_TICKS(3), .SYNC_STAGES(2), .INIT_LEVEL(1)
  ) dut_hi (
    .clk(clk), .reset(reset), .sw(sw_hi),
    .db(db_hi), .rise(rise_hi), .fall(fall_hi), .changed(changed_hi)
  );

  // Waits up to max_edges rising edges for db[ch] to reach level. Returns the
  // edge number (max_edges+1 on timeout), the pulses seen on that edge, and
  // whether any pulse on ch appeared before db moved.
  task automatic wait_db(input int ch, input logic level, input int max_edges,
                         output int n, output logic r, output logic f,
                         output logic early);
    n = max_edges + 1; r = 1'b0; f = 1'b0; early = 1'b0;
    for (int k = 1; k <= max_edges; k++) begin
      @(posedge clk); #1;
      if (db[ch] === level) begin
        n = k; r = rise[ch]; f = fall[ch];
        break;
      end
      if (rise[ch] !== 1'b0 || fall[ch] !== 1'b0) early = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; sw = 4'h0; sw_hi = 4'hF;
    #2 reset = 1'b0;
    #1;
    total++; if (db !== 4'h0) begin bad++; $display("FAIL reset_db: got %h want 0", db); end
    total++; if ({rise, fall, changed} !== 9'd0) begin bad++;
      $display("FAIL reset_pulses: got rise=%h fall=%h changed=%b want all 0", rise, fall, changed); end
    total++; if (db_hi !== 4'hF) begin bad++; $display("FAIL reset_db_init1: got %h want f", db_hi); end
    repeat (3) @(negedge clk);
    total++; if (db !== 4'h0 || db_hi !== 4'hF) begin bad++;
      $display("FAIL reset_hold: got db=%h db_hi=%h want 0/f", db, db_hi); end
    reset = 1'b1;
  endtask

  task automatic test_rise();
    int n; logic r, f, early, stray;
    @(negedge clk); sw[0] = 1'b1;
    wait_db(0, 1'b1, 20, n, r, f, early);
    total++; if (n < 12 || n > 15) begin bad++; $display("FAIL rise_latency: got %0d edges want 12..15", n); end
    total++; if (r !== 1'b1 || f !== 1'b0) begin bad++;
      $display("FAIL rise_pulse: got rise=%b fall=%b want 1/0", r, f); end
    total++; if (early !== 1'b0) begin bad++; $display("FAIL rise_early: pulse before db change"); end
    total++; if (changed !== 1'b0) begin bad++; $display("FAIL rise_changed_same: got %b want 0", changed); end
    @(posedge clk); #1;
    total++; if (rise[0] !== 1'b0 || changed !== 1'b1) begin bad++;
      $display("FAIL rise_after: got rise0=%b changed=%b want 0/1", rise[0], changed); end
    stray = 1'b0;
    repeat (24) begin
      @(posedge clk); #1;
      if (db !== 4'b0001 || rise !== 4'h0 || fall !== 4'h0) stray = 1'b1;
    end
    total++; if (stray !== 1'b0) begin bad++; $display("FAIL rise_hold: db=%h rise=%h fall=%h", db, rise, fall); end
  endtask

  task automatic test_glitch();
    logic stray = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); sw[1] = (k < 6);
      @(posedge clk); #1;
      if (db[1] !== 1'b0 || rise[1] !== 1'b0 || fall[1] !== 1'b0 || changed !== 1'b0) stray = 1'b1;
    end
    total++; if (stray !== 1'b0) begin bad++; $display("FAIL glitch: got activity on ch1, want none"); end
    total++; if (db !== 4'b0001) begin bad++; $display("FAIL glitch_db: got %h want 1", db); end
  endtask

  task automatic test_bounce();
    int n; logic r, f, early, stray;
    logic [3:0] idx;
    @(negedge clk); sw[2] = 1'b1;
    wait_db(2, 1'b1, 20, n, r, f, early);
    total++; if (n < 12 || n > 15 || r !== 1'b1) begin bad++;
      $display("FAIL bounce_setup: got %0d edges rise=%b want 12..15/1", n, r); end
    repeat (3) @(posedge clk);
    stray = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = 4'(i);
      @(negedge clk); sw[2] = idx[1];
      @(posedge clk); #1;
      if (db[2] !== 1'b1 || fall[2] !== 1'b0) stray = 1'b1;
    end
    total++; if (stray !== 1'b0) begin bad++; $display("FAIL bounce_hold: db2 moved during bounce"); end
    @(negedge clk); sw[2] = 1'b0;
    wait_db(2, 1'b0, 20, n, r, f, early);
    total++; if (n < 12 || n > 15) begin bad++; $display("FAIL bounce_latency: got %0d edges want 12..15", n); end
    total++; if (f !== 1'b1 || r !== 1'b0 || early !== 1'b0) begin bad++;
      $display("FAIL bounce_pulse: got fall=%b rise=%b early=%b want 1/0/0", f, r, early); end
    @(posedge clk); #1;
    total++; if (fall[2] !== 1'b0 || changed !== 1'b1) begin bad++;
      $display("FAIL bounce_after: got fall2=%b changed=%b want 0/1", fall[2], changed); end
  endtask

  task automatic test_simultaneous();
    int n; logic r, f, early;
    @(negedge clk); sw[2] = 1'b1;
    wait_db(2, 1'b1, 20, n, r, f, early);
    total++; if (n < 12 || n > 15) begin bad++; $display("FAIL simul_setup: got %0d edges want 12..15", n); end
    repeat (2) @(posedge clk);
    @(negedge clk); sw[2] = 1'b0; sw[3] = 1'b1;
    wait_db(2, 1'b0, 20, n, r, f, early);
    total++; if (n < 12 || n > 15) begin bad++; $display("FAIL simul_latency: got %0d edges want 12..15", n); end
    total++; if (rise !== 4'b1000 || fall !== 4'b0100) begin bad++;
      $display("FAIL simul_pulses: got rise=%h fall=%h want 8/4", rise, fall); end
    total++; if (db !== 4'b1001) begin bad++; $display("FAIL simul_db: got %h want 9", db); end
    @(posedge clk); #1;
    total++; if (changed !== 1'b1 || (rise | fall) !== 4'h0) begin bad++;
      $display("FAIL simul_after: got changed=%b rise=%h fall=%h want 1/0/0", changed, rise, fall); end
  endtask

  task automatic test_reset_mid();
    int n; logic r, f, early;
    @(negedge clk); sw[0] = 1'b0;
    wait_db(0, 1'b0, 20, n, r, f, early);
    total++; if (n < 12 || n > 15 || f !== 1'b1) begin bad++;
      $display("FAIL rmid_setup: got %0d edges fall=%b want 12..15/1", n, f); end
    repeat (2) @(posedge clk);
    @(negedge clk); sw[0] = 1'b1;
    repeat (6) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    total++; if (db !== 4'h0 || rise !== 4'h0 || fall !== 4'h0 || changed !== 1'b0) begin bad++;
      $display("FAIL rmid_async: got db=%h rise=%h fall=%h changed=%b want 0", db, rise, fall, changed); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wait_db(0, 1'b1, 20, n, r, f, early);
    total++; if (n < 12 || n > 15) begin bad++; $display("FAIL rmid_latency: got %0d edges want 12..15", n); end
    total++; if (r !== 1'b1 || early !== 1'b0 || db !== 4'b1001) begin bad++;
      $display("FAIL rmid_rise: got rise=%b early=%b db=%h want 1/0/9", r, early, db); end
  endtask

  task automatic test_init_high();
    logic stray = 1'b0;
    repeat (50) begin
      @(posedge clk); #1;
      if (db_hi !== 4'hF || rise_hi !== 4'h0 || fall_hi !== 4'h0 || changed_hi !== 1'b0) stray = 1'b1;
    end
    total++; if (stray !== 1'b0) begin bad++;
      $display("FAIL init_high: got db=%h rise=%h fall=%h changed=%b want f/0/0/0",
               db_hi, rise_hi, fall_hi, changed_hi); end
  endtask

  initial begin
    test_reset();
    test_rise();
    test_glitch();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    test_init_high();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
